dcsformer_gen: RTL and testbench

- Parametrised successor to the fixed 8x16 attention-style block.
- Loads an N x D token matrix X and forms the Gram matrix G = X·Xᵀ.
- Optionally applies per-row mean thresholding (RAT): zero every G entry below its row average.
- Multiplies the result by a streamed N x NCOL weight matrix W and emits N*NCOL results with output backpressure.
- Sits between the token buffer and the projection stage of the DCS datapath.

---
 rtl/dcsformer_gen.sv | 188 ++++++++++++++++++
 tb/tb_dcsformer_gen.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dcsformer_gen.sv
// Gram-matrix attention block: loads an N x D token matrix X, forms G = X*X^T,
// optionally zeroes entries below their row average, then multiplies by a streamed W.
module dcsformer_gen #(
  parameter int N    = 8,
  parameter int D    = 16,
  parameter int DW   = 8,
  parameter int NCOL = 1,
  parameter int OW   = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          thr_en,
  input  logic          i_valid,
  input  logic [DW-1:0] i_data,
  output logic          in_ready,
  input  logic          w_valid,
  input  logic [DW-1:0] w_data,
  output logic          w_ready,
  output logic          o_valid,
  output logic [OW-1:0] o_data,
  output logic          o_last,
  input  logic          o_ready
);

  localparam int LN  = $clog2(N);
  localparam int PW  = 2 * DW;
  localparam int GW  = 2 * DW + $clog2(D);
  localparam int RW  = GW + LN;
  localparam int YW  = GW + DW + LN;
  localparam int AW  = (YW > OW) ? YW : OW;
  localparam int XIW = $clog2(N * D);
  localparam int WIW = $clog2(N * NCOL);
  localparam int DCW = (D > 1) ? $clog2(D) : 1;
  localparam int CCW = (NCOL > 1) ? $clog2(NCOL) : 1;

  localparam logic [XIW-1:0] X_LAST = XIW'(N * D - 1);
  localparam logic [WIW-1:0] W_LAST = WIW'(N * NCOL - 1);
  localparam logic [LN-1:0]  N_LAST = LN'(N - 1);
  localparam logic [DCW-1:0] D_LAST = DCW'(D - 1);
  localparam logic [CCW-1:0] C_LAST = CCW'(NCOL - 1);

  typedef enum logic [2:0] {IDLE, LOAD, GRAM, WAIT_W, MUL, OUT} state_t;
  state_t state, state_nx;

  logic [DW-1:0] x_mem [N*D];
  logic [GW-1:0] g_mem [N*N];
  logic [DW-1:0] w_mem [N*NCOL];
  logic [OW-1:0] y_mem [N*NCOL];
  logic [RW-1:0] row_sum [N];

  logic [XIW-1:0] xk;
  logic [WIW-1:0] wk, ok;
  logic [LN-1:0]  ga, gb, ma, mb;
  logic [DCW-1:0] gd;
  logic [CCW-1:0] mc;
  logic           thr_q;
  logic [GW-1:0]  gacc, gacc_nx;
  logic [AW-1:0]  macc, macc_nx;

  logic           x_fire, w_fire, o_fire, g_done, m_done;
  logic [XIW-1:0] x_pa, x_pb;
  logic [PW-1:0]  prod_g;
  logic [GW-1:0]  g_sel, avg, a_val;
  logic [WIW-1:0] w_idx, y_idx;

  assign x_fire = i_valid && in_ready;
  assign w_fire = w_valid && w_ready;
  assign o_fire = o_valid && o_ready;
  assign g_done = (state == GRAM) && (ga == N_LAST) && (gb == N_LAST) && (gd == D_LAST);
  assign m_done = (state == MUL) && (ma == N_LAST) && (mb == N_LAST) && (mc == C_LAST);

  // Gram phase: one X*X product per cycle, rows a, columns b, feature d innermost
  assign x_pa    = XIW'(int'(ga) * D + int'(gd));
  assign x_pb    = XIW'(int'(gb) * D + int'(gd));
  assign prod_g  = PW'(x_mem[x_pa]) * PW'(x_mem[x_pb]);
  assign gacc_nx = ((gd == '0) ? '0 : gacc) + GW'(prod_g);

  // Thresholding is applied on the fly as G is read back, using row sums gathered during GRAM
  assign g_sel   = g_mem[{ma, mb}];
  assign avg     = GW'(row_sum[ma] >> LN);
  assign a_val   = (thr_q && (g_sel < avg)) ? '0 : g_sel;
  assign w_idx   = WIW'(int'(mb) * NCOL + int'(mc));
  assign y_idx   = WIW'(int'(ma) * NCOL + int'(mc));
  assign macc_nx = ((mb == '0) ? '0 : macc) + AW'(a_val) * AW'(w_mem[w_idx]);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    in_ready = 1'b0;
    w_ready  = 1'b0;
    o_valid  = 1'b0;
    unique case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (i_valid) state_nx = LOAD;
      end
      LOAD: begin
        in_ready = 1'b1;
        if (i_valid && (xk == X_LAST)) state_nx = GRAM;
      end
      GRAM: if (g_done) state_nx = WAIT_W;
      WAIT_W: begin
        w_ready = 1'b1;
        if (w_valid && (wk == W_LAST)) state_nx = MUL;
      end
      MUL: if (m_done) state_nx = OUT;
      OUT: begin
        o_valid = 1'b1;
        if (o_ready && (ok == W_LAST)) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  assign o_data = o_valid ? y_mem[ok] : '0;
  assign o_last = o_valid && (ok == W_LAST);

  // Every counter wraps to zero at the end of its phase so the next frame starts clean
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      xk    <= '0;
      wk    <= '0;
      ok    <= '0;
      ga    <= '0;
      gb    <= '0;
      gd    <= '0;
      ma    <= '0;
      mb    <= '0;
      mc    <= '0;
      thr_q <= 1'b0;
      gacc  <= '0;
      macc  <= '0;
      for (int i = 0; i < N; i++) row_sum[i] <= '0;
    end else begin
      if (x_fire) begin
        if (state == IDLE) begin
          thr_q <= thr_en;
          for (int i = 0; i < N; i++) row_sum[i] <= '0;
        end
        xk <= (xk == X_LAST) ? '0 : xk + 1'b1;
      end
      if (state == GRAM) begin
        gacc <= gacc_nx;
        if (gd == D_LAST) begin
          row_sum[ga] <= row_sum[ga] + RW'(gacc_nx);
          gd <= '0;
          if (gb == N_LAST) begin
            gb <= '0;
            ga <= ga + 1'b1;
          end else begin
            gb <= gb + 1'b1;
          end
        end else begin
          gd <= gd + 1'b1;
        end
      end
      if (w_fire) wk <= (wk == W_LAST) ? '0 : wk + 1'b1;
      if (state == MUL) begin
        macc <= macc_nx;
        if (mb == N_LAST) begin
          mb <= '0;
          if (mc == C_LAST) begin
            mc <= '0;
            ma <= ma + 1'b1;
          end else begin
            mc <= mc + 1'b1;
          end
        end else begin
          mb <= mb + 1'b1;
        end
      end
      if (o_fire) ok <= (ok == W_LAST) ? '0 : ok + 1'b1;
    end
  end

  // Data stores hold no reset; every entry is rewritten before it is read in a frame
  always_ff @(posedge clk) begin
    if (x_fire) x_mem[xk] <= i_data;
    if ((state == GRAM) && (gd == D_LAST)) g_mem[{ga, gb}] <= gacc_nx;
    if (w_fire) w_mem[wk] <= w_data;
    if ((state == MUL) && (mb == N_LAST)) y_mem[y_idx] <= OW'(macc_nx);
  end

endmodule

// File: tb/tb_dcsformer_gen.sv
// Self-checking bench for dcsformer_gen: table-driven frames with a scoreboard queue,
// plus hand-written sequences for backpressure, NCOL=2 and mid-frame reset.
module tb_dcsformer_gen;

  localparam int N = 8, D = 16, DW = 8, OW = 32, NCOL = 1, NCOL2 = 2;
  localparam int TMO = 3000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n, thr_en, i_valid, in_ready, w_valid, w_ready;
  logic          o_valid, o_last, o_ready;
  logic [DW-1:0] i_data, w_data;
  logic [OW-1:0] o_data;

  logic          i_valid2, in_ready2, w_valid2, w_ready2, o_valid2, o_last2, o_ready2;
  logic [DW-1:0] i_data2, w_data2;
  logic [OW-1:0] o_data2;

  dcsformer_gen #(.N(N), .D(D), .DW(DW), .NCOL(NCOL), .OW(OW)) dut (
    .clk(clk), .rst_n(rst_n), .thr_en(thr_en),
    .i_valid(i_valid), .i_data(i_data), .in_ready(in_ready),
    .w_valid(w_valid), .w_data(w_data), .w_ready(w_ready),
    .o_valid(o_valid), .o_data(o_data), .o_last(o_last), .o_ready(o_ready)
  );

  dcsformer_gen #(.N(N), .D(D), .DW(DW), .NCOL(NCOL2), .OW(OW)) dut2 (
    .clk(clk), .rst_n(rst_n), .thr_en(1'b0),
    .i_valid(i_valid2), .i_data(i_data2), .in_ready(in_ready2),
    .w_valid(w_valid2), .w_data(w_data2), .w_ready(w_ready2),
    .o_valid(o_valid2), .o_data(o_data2), .o_last(o_last2), .o_ready(o_ready2)
  );

  typedef struct {
    logic [OW-1:0] data;
    logic          last;
  } exp_t;

  typedef struct {
    int     xmode;
    int     thr;
    int     wval;
    int     gap;
    int     stall;
    int     busy_iv;
    longint y0;
    longint y1;
    longint y7;
  } vec_t;

  exp_t   exp_q[$];
  vec_t   vecs[5];
  int     n_checks = 0;
  int     n_fail   = 0;
  int     cap_n    = 0;
  int     cap2_n   = 0;
  longint cap[N*NCOL];
  longint exp_y[N*NCOL];
  int     xm[N][D];
  int     wm[N][NCOL];

  task automatic check_output(input string name, input longint act, input longint req);
    n_checks++;
    if (act != req) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0d, required %0d", name, act, req);
    end
  endtask

  task automatic fail_timeout(input string name);
    n_checks++;
    n_fail++;
    $display("[TB] FAIL %s: got timeout, required handshake", name);
  endtask

  // Reference model: plain loops over the matrices, independent of the RTL schedule
  task automatic build_model(input int xmode, input int thr, input int wval);
    longint g[N][N];
    longint rs, av, acc, av_el;
    for (int a = 0; a < N; a++)
      for (int d = 0; d < D; d++)
        xm[a][d] = (xmode == 0) ? 1 : (xmode == 2) ? 255 : ((d == 0) ? a + 1 : 0);
    for (int b = 0; b < N; b++)
      for (int c = 0; c < NCOL; c++) wm[b][c] = wval;
    for (int a = 0; a < N; a++)
      for (int b = 0; b < N; b++) begin
        g[a][b] = 0;
        for (int d = 0; d < D; d++) g[a][b] += longint'(xm[a][d]) * xm[b][d];
      end
    for (int a = 0; a < N; a++) begin
      rs = 0;
      for (int b = 0; b < N; b++) rs += g[a][b];
      av = rs / N;
      for (int c = 0; c < NCOL; c++) begin
        acc = 0;
        for (int b = 0; b < N; b++) begin
          av_el = ((thr != 0) && (g[a][b] < av)) ? 0 : g[a][b];
          acc += av_el * wm[b][c];
        end
        exp_y[a*NCOL+c] = acc & 64'hFFFF_FFFF;
      end
    end
  endtask

  task automatic send_x(input logic [DW-1:0] d, input logic thr);
    int t;
    t = 0;
    i_valid = 1'b1;
    i_data  = d;
    thr_en  = thr;
    while (!in_ready && t < TMO) begin
      @(posedge clk); #1;
      t++;
    end
    if (!in_ready) fail_timeout("x_handshake");
    @(posedge clk); #1;
    i_valid = 1'b0;
  endtask

  task automatic send_w(input logic [DW-1:0] d, output int waited);
    int t;
    t = 0;
    w_valid = 1'b1;
    w_data  = d;
    while (!w_ready && t < TMO) begin
      @(posedge clk); #1;
      t++;
    end
    if (!w_ready) fail_timeout("w_handshake");
    @(posedge clk); #1;
    w_valid = 1'b0;
    waited  = t;
  endtask

  task automatic drive_x(input int thr, input int gap);
    for (int k = 0; k < N*D; k++) begin
      if (gap != 0 && k > 0) repeat (2) begin @(posedge clk); #1; end
      send_x(DW'(xm[k/D][k%D]), (k == 0) ? thr[0] : ~thr[0]);
    end
  endtask

  task automatic apply_stimulus(input vec_t v);
    int t, waited;
    cap_n = 0;
    build_model(v.xmode, v.thr, v.wval);
    for (int i = 0; i < N*NCOL; i++)
      exp_q.push_back('{data: OW'(exp_y[i]), last: (i == N*NCOL-1)});
    drive_x(v.thr, v.gap);
    for (int k = 0; k < N*NCOL; k++) begin
      if (v.gap != 0 && k > 0) repeat (2) begin @(posedge clk); #1; end
      send_w(DW'(wm[k/NCOL][k%NCOL]), waited);
      if (k == 0) check_output("w_ready_latency_ok", (waited <= N*N*D+4), 1);
    end
    if (v.busy_iv != 0) begin
      i_valid = 1'b1;
      i_data  = 8'hFF;
      check_output("in_ready_low_in_mul", in_ready, 0);
    end
    t = 0;
    while (!o_valid && t < TMO) begin
      @(posedge clk); #1;
      t++;
    end
    i_valid = 1'b0;
    check_output("o_valid_latency_ok", (t <= N*N*NCOL+4), 1);
    if (v.stall != 0) begin
      t = 0;
      while (cap_n < 2 && t < TMO) begin @(posedge clk); #1; t++; end
      o_ready = 1'b0;
      repeat (3) begin
        check_output("stall_o_valid", o_valid, 1);
        check_output("stall_o_data", o_data, exp_y[2]);
        check_output("stall_o_last", o_last, 0);
        @(posedge clk); #1;
      end
      o_ready = 1'b1;
    end
    t = 0;
    while (cap_n < N*NCOL && t < TMO) begin @(posedge clk); #1; t++; end
    if (cap_n < N*NCOL) fail_timeout("frame_outputs");
    check_output("post_frame_o_valid", o_valid, 0);
    check_output("post_frame_in_ready", in_ready, 1);
    check_output("scoreboard_empty", exp_q.size(), 0);
    check_output("table_y0", cap[0], v.y0);
    check_output("table_y1", cap[1], v.y1);
    check_output("table_y7", cap[N-1], v.y7);
  endtask

  task automatic reset_sequence();
    int waited;
    build_model(0, 0, 1);
    drive_x(0, 0);
    for (int k = 0; k < 3; k++) send_w(8'd1, waited);
    rst_n = 1'b0;
    #1;
    check_output("rst_o_valid", o_valid, 0);
    check_output("rst_o_data", o_data, 0);
    check_output("rst_o_last", o_last, 0);
    check_output("rst_w_ready", w_ready, 0);
    check_output("rst_in_ready", in_ready, 1);
    exp_q.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    apply_stimulus('{0, 0, 1, 0, 0, 0, 128, 128, 128});
  endtask

  task automatic run_dut2();
    int t;
    for (int k = 0; k < N*D; k++) begin
      i_valid2 = 1'b1;
      i_data2  = 8'd1;
      t = 0;
      while (!in_ready2 && t < TMO) begin @(posedge clk); #1; t++; end
      @(posedge clk); #1;
    end
    i_valid2 = 1'b0;
    for (int k = 0; k < N*NCOL2; k++) begin
      w_valid2 = 1'b1;
      w_data2  = (k % 2 == 1) ? 8'd2 : 8'd1;
      t = 0;
      while (!w_ready2 && t < TMO) begin @(posedge clk); #1; t++; end
      if (!w_ready2) fail_timeout("w2_handshake");
      @(posedge clk); #1;
    end
    w_valid2 = 1'b0;
    t = 0;
    while (cap2_n < N*NCOL2 && t < TMO) begin @(posedge clk); #1; t++; end
    check_output("y2_count", cap2_n, N*NCOL2);
  endtask

  // Outputs are sampled on the falling edge, where a valid&&ready pair means a handshake follows
  always @(negedge clk) begin
    if (rst_n && o_valid && o_ready) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("[TB] FAIL unexpected_output: got %0d, required no output", o_data);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check_output("y_data", o_data, e.data);
        check_output("y_last", o_last, e.last);
      end
      if (cap_n < N*NCOL) cap[cap_n] = o_data;
      cap_n++;
    end
    if (rst_n && o_valid2 && o_ready2) begin
      check_output("y2_data", o_data2, (cap2_n % 2 == 0) ? 128 : 256);
      check_output("y2_last", o_last2, (cap2_n == N*NCOL2-1) ? 1 : 0);
      cap2_n++;
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got timeout, required end of test");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    vecs[0] = '{0, 1, 1,   0, 0, 0, 128, 128, 128};
    vecs[1] = '{1, 0, 1,   0, 0, 0, 36, 72, 288};
    vecs[2] = '{1, 1, 1,   0, 0, 0, 30, 52, 208};
    vecs[3] = '{2, 0, 255, 0, 0, 0, 2122416000, 2122416000, 2122416000};
    vecs[4] = '{0, 1, 1,   1, 1, 1, 128, 128, 128};

    rst_n = 1'b0;
    thr_en = 1'b0;
    i_valid = 1'b0;
    i_data = '0;
    w_valid = 1'b0;
    w_data = '0;
    o_ready = 1'b1;
    i_valid2 = 1'b0;
    i_data2 = '0;
    w_valid2 = 1'b0;
    w_data2 = '0;
    o_ready2 = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_output("reset_in_ready", in_ready, 1);
    check_output("reset_w_ready", w_ready, 0);
    check_output("reset_o_valid", o_valid, 0);
    check_output("reset_o_data", o_data, 0);
    check_output("reset_o_last", o_last, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    run_dut2();
    for (int i = 0; i < 5; i++) apply_stimulus(vecs[i]);
    reset_sequence();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
